cordic_engine: RTL and testbench
================================

# cordic_engine

Parametrised, iterative CORDIC engine supporting both rotation mode (rotate a vector by an angle) and vectoring mode (magnitude and phase of a vector). It replaces the fixed 8-stage, rotation-only, 32-bit pipeline. The generalisations are:
- configurable data width, angle width and iteration count
- full ±180° angle range via quadrant pre-rotation
- built-in gain compensation
- a valid/ready handshake on input and output

One datapath is reused for ITER cycles, so each transaction costs ITER+2 cycles.

## Interface
- WIDTH, 16, signed two's-complement width of x/y in and out
- ANGLE_W, 16, signed angle width; 2^(ANGLE_W-1) LSB = 180°, so -2^(ANGLE_W-1) encodes ±180°
- ITER, 14, micro-rotations per transaction; legal range 8..min(ANGLE_W-2, 24)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  input transaction present
- in_ready  out  1  engine accepts input; high only in IDLE
- mode  in  1  0 = rotation, 1 = vectoring; sampled on accept
- x_in, y_in  in  WIDTH  signed input vector
- z_in  in  ANGLE_W  signed rotation angle; ignored in vectoring mode
- out_valid  out  1  result present; held until out_ready
- out_ready  in  1  downstream accepts result
- x_out, y_out  out  WIDTH  gain-corrected signed result
- z_out  out  ANGLE_W  rotation mode: residual angle; vectoring mode: atan2(y_in, x_in)

## Operation
- FSM states: IDLE, ITERATE, SCALE, HOLD. Reset value is IDLE.
- IDLE: in_ready=1. On in_valid & in_ready:
  - latch mode.
  - apply pre-rotation, sign-extending into WIDTH+2-bit internal x/y registers (2 guard bits).
  - clear iteration counter i=0.
  - go to ITERATE.
- Pre-rotation, rotation mode: if z_in[ANGLE_W-1] ^ z_in[ANGLE_W-2], the angle is beyond ±90°. Then x=-x_in, y=-y_in, z=z_in+2^(ANGLE_W-1) (wraps). Otherwise pass through.
- Pre-rotation, vectoring mode:
  - if x_in<0: x=-x_in, y=-y_in, z=-2^(ANGLE_W-1) (180°).
  - otherwise z=0.
- Negating the most negative input saturates to the most positive value.
- ITERATE, one micro-rotation per cycle:
  - direction d = +1 if (rotation: z>=0) / (vectoring: y<0), else -1.
  - x'=x-d·(y>>>i), y'=y+d·(x>>>i), z'=z-d·atan_i.
  - all shifts are arithmetic; z wraps modulo 2^ANGLE_W.
  - i increments; after i=ITER-1, go to SCALE.
- atan_i = round(atan(2^-i)/π · 2^(ANGLE_W-1)). This is a constant table held at 32-bit precision and rounded down to ANGLE_W.
- SCALE:
  - x_out = sat_WIDTH((x·K + 2^31)>>>32) with K = 2608131496 (0.6072529350, Q0.32); y_out likewise.
  - z_out = z.
  - assert out_valid; go to HOLD.
- HOLD: outputs stable while out_valid & !out_ready. On out_ready, drop out_valid and return to IDLE next cycle.
- in_valid is ignored outside IDLE. mode/x_in/y_in/z_in are don't-care when not accepted.

## Timing
- Reset (async assert, sync deassert by the upstream reset synchroniser):
  - state=IDLE, in_ready=1, out_valid=0.
  - x_out=y_out=0, z_out=0.
  - all internal registers 0.
- Accept at edge n → out_valid rises after edge n+ITER+1; consumable at edge n+ITER+2 at the earliest.
- Next accept is possible at edge n+ITER+3 (minimum initiation interval ITER+3).
- in_ready drops the cycle after accept and returns the cycle after the output handshake. Same-cycle out_ready and in_valid never produce a combinational in_ready.
- Reset asserted mid-transaction: abort immediately, all outputs take their reset values, and no partial result is ever presented.
- Accuracy at defaults: |error| ≤ 4 LSB on x/y for |x_in|,|y_in| ≤ 2^(WIDTH-2); z_out error ≤ 4 LSB.
- Vector magnitude at most √2·2^(WIDTH-1), so the guard bits prevent internal overflow.

## Test plan
- Rotation, x=10000, y=0, z=16384 (90°) → after exactly 16 cycles x_out≈0, y_out≈10000 (±4), z_out≈0.
- Rotation, x=10000, y=0, z=-32768 (180°) → x_out≈-10000, y_out≈0 (±4); checks pre-rotation and wrap.
- Vectoring, x=3000, y=4000 → x_out≈5000, y_out≈0, z_out≈9672 (53.13°) ±4.
- Vectoring, x=-10000, y=0 → x_out≈10000, z_out≈-32768 (±180° boundary, ±4 with wrap).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → outputs stable, in_ready=0, second in_valid ignored. Release → one handshake, then in_ready=1 on the next cycle.
- Assert reset at iteration 7, then restart with the first vector → outputs zero during reset, then the correct result of the new transaction only.

Source files
------------

// File: rtl/cordic_engine.sv
// Iterative CORDIC engine: rotation and vectoring modes, quadrant pre-rotation,
// gain compensation and valid/ready handshakes. One micro-rotation per cycle.
module cordic_engine #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned ANGLE_W = 16,
  parameter int unsigned ITER    = 14
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     mode,
  input  logic signed [WIDTH-1:0]  x_in,
  input  logic signed [WIDTH-1:0]  y_in,
  input  logic signed [ANGLE_W-1:0] z_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [WIDTH-1:0]  x_out,
  output logic signed [WIDTH-1:0]  y_out,
  output logic signed [ANGLE_W-1:0] z_out
);

  localparam int unsigned IW = WIDTH + 2;
  localparam int unsigned CW = $clog2(ITER);
  localparam int unsigned PW = IW + 33;
  localparam int unsigned SH = 32 - ANGLE_W;

  localparam logic [32:0] ATAN_RND = (33'd1 << SH) >> 1;
  localparam logic [31:0] K_GAIN   = 32'd2608131496;
  localparam logic [CW-1:0] LAST   = CW'(ITER - 1);
  localparam logic signed [ANGLE_W-1:0] HALF = {1'b1, {(ANGLE_W-1){1'b0}}};

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ITERATE = 2'd1;
  localparam logic [1:0] SCALE   = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  // atan(2^-i) with 2^32 = one full turn
  function automatic logic [31:0] atan32(input logic [4:0] idx);
    logic [31:0] r;
    case (idx)
      5'd0:  r = 32'd536870912;
      5'd1:  r = 32'd316933406;
      5'd2:  r = 32'd167458907;
      5'd3:  r = 32'd85004756;
      5'd4:  r = 32'd42667331;
      5'd5:  r = 32'd21354465;
      5'd6:  r = 32'd10679838;
      5'd7:  r = 32'd5340245;
      5'd8:  r = 32'd2670163;
      5'd9:  r = 32'd1335087;
      5'd10: r = 32'd667544;
      5'd11: r = 32'd333772;
      5'd12: r = 32'd166886;
      5'd13: r = 32'd83443;
      5'd14: r = 32'd41722;
      5'd15: r = 32'd20861;
      5'd16: r = 32'd10430;
      5'd17: r = 32'd5215;
      5'd18: r = 32'd2608;
      5'd19: r = 32'd1304;
      5'd20: r = 32'd652;
      5'd21: r = 32'd326;
      5'd22: r = 32'd163;
      5'd23: r = 32'd81;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Negation that maps the most negative value to the most positive one.
  function automatic logic signed [IW-1:0] neg_sat(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] r;
    if (v == {1'b1, {(WIDTH-1){1'b0}}}) r = {1'b0, {(WIDTH-1){1'b1}}};
    else                                 r = -v;
    return {{2{r[WIDTH-1]}}, r};
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(input logic [IW:0] v);
    logic signed [WIDTH-1:0] r;
    if ((&v[IW:WIDTH-1]) || (~|v[IW:WIDTH-1])) r = v[WIDTH-1:0];
    else if (v[IW])                            r = {1'b1, {(WIDTH-1){1'b0}}};
    else                                       r = {1'b0, {(WIDTH-1){1'b1}}};
    return r;
  endfunction

  logic [1:0]                state_q;
  logic                      mode_q;
  logic signed [IW-1:0]      x_q, y_q;
  logic signed [ANGLE_W-1:0] z_q;
  logic [CW-1:0]             iter_q;
  logic                      out_valid_q;
  logic signed [WIDTH-1:0]   x_out_q, y_out_q;
  logic signed [ANGLE_W-1:0] z_out_q;

  logic signed [IW-1:0]      x_pre, y_pre, x_nxt, y_nxt, x_sh, y_sh;
  logic signed [ANGLE_W-1:0] z_pre, z_nxt, atan_i;
  logic [32:0]               atan_sum;
  logic                      dir_pos;
  logic [PW-1:0]             x_prod, y_prod;
  logic signed [WIDTH-1:0]   x_scaled, y_scaled;
  logic                      unused_bits;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign z_out     = z_out_q;

  // Quadrant pre-rotation so the micro-rotations only need to cover +/-90 deg.
  always_comb begin
    x_pre = {{2{x_in[WIDTH-1]}}, x_in};
    y_pre = {{2{y_in[WIDTH-1]}}, y_in};
    z_pre = z_in;
    if (!mode) begin
      if (z_in[ANGLE_W-1] ^ z_in[ANGLE_W-2]) begin
        x_pre = neg_sat(x_in);
        y_pre = neg_sat(y_in);
        z_pre = z_in + HALF;
      end
    end else begin
      z_pre = '0;
      if (x_in[WIDTH-1]) begin
        x_pre = neg_sat(x_in);
        y_pre = neg_sat(y_in);
        z_pre = HALF;
      end
    end
  end

  always_comb begin
    atan_sum = {1'b0, atan32(5'(iter_q))} + ATAN_RND;
    atan_i   = atan_sum[31:SH];
    x_sh     = x_q >>> iter_q;
    y_sh     = y_q >>> iter_q;
    dir_pos  = mode_q ? y_q[IW-1] : ~z_q[ANGLE_W-1];
    if (dir_pos) begin
      x_nxt = x_q - y_sh;
      y_nxt = y_q + x_sh;
      z_nxt = z_q - atan_i;
    end else begin
      x_nxt = x_q + y_sh;
      y_nxt = y_q - x_sh;
      z_nxt = z_q + atan_i;
    end
  end

  // Gain compensation: (v * K + 2^31) >>> 32 with K in Q0.32.
  always_comb begin
    x_prod   = {{33{x_q[IW-1]}}, x_q} * {{(IW+1){1'b0}}, K_GAIN};
    y_prod   = {{33{y_q[IW-1]}}, y_q} * {{(IW+1){1'b0}}, K_GAIN};
    x_prod   = x_prod + (PW'(1) << 31);
    y_prod   = y_prod + (PW'(1) << 31);
    x_scaled = sat(x_prod[PW-1:32]);
    y_scaled = sat(y_prod[PW-1:32]);
  end

  assign unused_bits = ^{x_prod, y_prod, atan_sum};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      iter_q      <= '0;
      out_valid_q <= 1'b0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      z_out_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mode_q  <= mode;
            x_q     <= x_pre;
            y_q     <= y_pre;
            z_q     <= z_pre;
            iter_q  <= '0;
            state_q <= ITERATE;
          end
        end
        ITERATE: begin
          x_q    <= x_nxt;
          y_q    <= y_nxt;
          z_q    <= z_nxt;
          iter_q <= iter_q + CW'(1);
          if (iter_q == LAST) state_q <= SCALE;
        end
        SCALE: begin
          x_out_q     <= x_scaled;
          y_out_q     <= y_scaled;
          z_out_q     <= z_q;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        default: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_engine.sv
// Bench for cordic_engine: vector table against ideal trig values, plus
// backpressure and mid-transaction reset sequences.
module tb_cordic_engine;

  localparam int WIDTH   = 16;
  localparam int ANGLE_W = 16;
  localparam int ITER    = 14;

  logic                      clock = 1'b0;
  logic                      reset = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic                      mode = 1'b0;
  logic signed [WIDTH-1:0]   x_in = '0;
  logic signed [WIDTH-1:0]   y_in = '0;
  logic signed [ANGLE_W-1:0] z_in = '0;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic signed [WIDTH-1:0]   x_out, y_out;
  logic signed [ANGLE_W-1:0] z_out;

  cordic_engine #(
    .WIDTH  (WIDTH),
    .ANGLE_W(ANGLE_W),
    .ITER   (ITER)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .x_in     (x_in),
    .y_in     (y_in),
    .z_in     (z_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x_out    (x_out),
    .y_out    (y_out),
    .z_out    (z_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit m;
    int x, y, z;
    int ex, ey, ez;
    int tol;
  } vec_t;

  typedef struct {
    int ex, ey, ez;
    int tol;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[9];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int act, input int exp, input int tol,
                       input bit wrap);
    int diff;
    logic signed [ANGLE_W-1:0] dw;
    diff = act - exp;
    if (wrap) begin
      dw   = ANGLE_W'(diff);
      diff = int'(dw);
    end
    n_checks++;
    if (diff > tol || diff < -tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic send(input vec_t v);
    exp_t e;
    int   t = 0;
    while (!in_ready && t < 64) begin
      @(posedge clock); #1;
      t++;
    end
    check("in_ready before accept", int'(in_ready), 1, 0, 0);
    in_valid = 1'b1;
    mode     = v.m;
    x_in     = WIDTH'(v.x);
    y_in     = WIDTH'(v.y);
    z_in     = ANGLE_W'(v.z);
    @(posedge clock); #1;
    in_valid = 1'b0;
    e.ex = v.ex; e.ey = v.ey; e.ez = v.ez; e.tol = v.tol;
    sb_q.push_back(e);
  endtask

  // Call right after send: latency is counted from the accepting edge.
  task automatic receive(input string name, output exp_t e);
    int lat = 0;
    e = '{0, 0, 0, 0};
    while (!out_valid && lat < 4 * ITER) begin
      @(posedge clock); #1;
      lat++;
    end
    check({name, " latency"}, lat, ITER + 1, 0, 0);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s scoreboard: got a result, expected none queued", name);
    end else begin
      e = sb_q.pop_front();
      check({name, " x_out"}, int'(x_out), e.ex, e.tol, 1'b0);
      check({name, " y_out"}, int'(y_out), e.ey, e.tol, 1'b0);
      check({name, " z_out"}, int'(z_out), e.ez, 4, 1'b1);
    end
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clock); #1;
    check({name, " out_valid after handshake"}, int'(out_valid), 0, 0, 0);
    check({name, " in_ready after handshake"}, int'(in_ready), 1, 0, 0);
  endtask

  task automatic quiet_window(input string name, input int cycles);
    int hits = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clock); #1;
      if (out_valid) hits++;
    end
    check({name, " spurious out_valid cycles"}, hits, 0, 0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    // mode, x, y, z, expected x, y, z (ideal), tolerance
    vecs[0] = '{1'b0,  10000,      0,  16384,  0,     10000,      0, 4};
    vecs[1] = '{1'b0,  10000,      0, -32768, -10000,     0,      0, 4};
    vecs[2] = '{1'b1,   3000,   4000,      0,  5000,      0,   9672, 4};
    vecs[3] = '{1'b1, -10000,      0,      0,  10000,     0, -32768, 4};
    vecs[4] = '{1'b0,      0,   8000,  -8192,  5657,   5657,      0, 4};
    vecs[5] = '{1'b0,  12000,  -5000,  24576, -4950,  12021,      0, 4};
    vecs[6] = '{1'b1,  -6000,  -8000,      0,  10000,     0, -23096, 4};
    vecs[7] = '{1'b1,      0, -12000,      0,  12000,     0, -16384, 4};
    vecs[8] = '{1'b0, -32768,      0, -32768,  32767,     0,      0, 8};

    repeat (2) @(posedge clock);
    #1;
    check("reset in_ready", int'(in_ready), 1, 0, 0);
    check("reset out_valid", int'(out_valid), 0, 0, 0);
    check("reset x_out", int'(x_out), 0, 0, 0);
    check("reset y_out", int'(y_out), 0, 0, 0);
    check("reset z_out", int'(z_out), 0, 0, 0);
    reset = 1'b1;
    @(posedge clock); #1;

    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(vecs[i]);
      receive($sformatf("vec%0d", i), e);
      handshake($sformatf("vec%0d", i));
    end

    // Backpressure: result must stay put and a second request must be ignored.
    out_ready = 1'b0;
    send(vecs[0]);
    receive("bp", e);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      mode     = 1'b1;
      x_in     = 16'sd3000;
      y_in     = 16'sd4000;
      z_in     = '0;
      @(posedge clock); #1;
      check("bp out_valid held", int'(out_valid), 1, 0, 0);
      check("bp in_ready low", int'(in_ready), 0, 0, 0);
      check("bp x_out stable", int'(x_out), e.ex, e.tol, 1'b0);
      check("bp y_out stable", int'(y_out), e.ey, e.tol, 1'b0);
      check("bp z_out stable", int'(z_out), e.ez, 4, 1'b1);
    end
    in_valid = 1'b0;
    handshake("bp");
    quiet_window("bp", ITER + 4);

    // Reset while iterating: abort, then run the first vector from scratch.
    send(vecs[5]);
    repeat (7) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      check("rst out_valid", int'(out_valid), 0, 0, 0);
      check("rst in_ready", int'(in_ready), 1, 0, 0);
      check("rst x_out", int'(x_out), 0, 0, 0);
      check("rst y_out", int'(y_out), 0, 0, 0);
      check("rst z_out", int'(z_out), 0, 0, 0);
      @(posedge clock); #1;
    end
    sb_q.delete();
    reset = 1'b1;
    @(posedge clock); #1;
    send(vecs[0]);
    receive("restart", e);
    handshake("restart");
    quiet_window("restart", ITER + 4);
    check("scoreboard drained", sb_q.size(), 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
